// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : ALU opcode encoding and request type shared by the ALU and its issue stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_OP_W       = 3;
    localparam int ALU_DATA_WIDTH = 32;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic [ALU_DATA_WIDTH-1:0] a;
        logic [ALU_DATA_WIDTH-1:0] b;
        alu_op_t                   op;
    } alu_req_t;

endpackage

`default_nettype wire

// File: rtl/alu_issue_fifo.sv
// ============================================================================
// Module   : alu_issue_fifo
// Purpose  : Synchronous FIFO with push/pop, full/empty flags and occupancy count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == c_cnt_full);
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign rdata  = r_mem[r_rd_ptr];
    assign count  = r_count;

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Operand FIFO feeding the combinational ALU plus a tagged, registered
//            result stage. Optional stats counters under ALU_ISSUE_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TAG_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_a,
    input  logic [DATA_WIDTH-1:0]        in_b,
    input  logic [ALU_OP_W-1:0]          in_op,
    output logic [DATA_WIDTH-1:0]        alu_a,
    output logic [DATA_WIDTH-1:0]        alu_b,
    output logic [ALU_OP_W-1:0]          alu_op,
    input  logic [DATA_WIDTH-1:0]        alu_result,
    input  logic                         alu_zero,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_result,
    output logic                         out_zero,
    output logic [TAG_W-1:0]             out_tag,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [31:0]                  stat_issued,
    output logic [31:0]                  stat_stall
);

    localparam int REQ_W = 2*DATA_WIDTH + ALU_OP_W;

    localparam logic [TAG_W-1:0] c_tag_one = TAG_W'(1);

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    out_state_t             r_state;
    logic [DATA_WIDTH-1:0]  r_result;
    logic                   r_zero;
    logic [TAG_W-1:0]       r_tag;
    logic [TAG_W-1:0]       r_tag_cnt;

    logic [REQ_W-1:0]       w_wdata;
    logic [REQ_W-1:0]       w_rdata;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_issue;

    assign w_wdata  = {in_a, in_b, in_op};
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign w_issue  = !w_empty && ((r_state == OUT_EMPTY) || out_ready);

    alu_issue_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_issue),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_count)
    );

    // Stale storage would otherwise leak onto the ALU inputs when nothing is queued.
    assign alu_a  = w_empty ? '0 : w_rdata[REQ_W-1 -: DATA_WIDTH];
    assign alu_b  = w_empty ? '0 : w_rdata[ALU_OP_W +: DATA_WIDTH];
    assign alu_op = w_empty ? '0 : w_rdata[ALU_OP_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= OUT_EMPTY;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_tag     <= '0;
            r_tag_cnt <= '0;
        end else begin
            case (r_state)
                OUT_EMPTY: if (w_issue)               r_state <= OUT_FULL;
                OUT_FULL:  if (out_ready && !w_issue) r_state <= OUT_EMPTY;
            endcase
            if (w_issue) begin
                r_result  <= alu_result;
                r_zero    <= alu_zero;
                r_tag     <= r_tag_cnt;
                r_tag_cnt <= r_tag_cnt + c_tag_one;
            end
        end
    end

    assign out_valid  = (r_state == OUT_FULL);
    assign out_result = r_result;
    assign out_zero   = r_zero;
    assign out_tag    = r_tag;

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_issue) begin
                r_stat_issued <= r_stat_issued + 32'd1;
            end
            if (in_valid && w_full) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_stall  = r_stat_stall;
`else
    assign stat_issued = '0;
    assign stat_stall  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Directed and randomized bench for alu_issue_stage with a behavioural
//            ALU and a result scoreboard. Honours ALU_ISSUE_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 2;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_a;
    logic [DW-1:0]     in_b;
    logic [2:0]        in_op;
    logic [DW-1:0]     alu_a;
    logic [DW-1:0]     alu_b;
    logic [2:0]        alu_op;
    logic [DW-1:0]     alu_result;
    logic              alu_zero;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_result;
    logic              out_zero;
    logic [TAG_W-1:0]  out_tag;
    logic [CNT_W-1:0]  fifo_count;
    logic [31:0]       stat_issued;
    logic [31:0]       stat_stall;

    alu_issue_stage #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .TAG_W      (TAG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_tag     (out_tag),
        .fifo_count  (fifo_count),
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [2:0] op);
        case (alu_op_t'(op))
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLL: return a << b[4:0];
            ALU_SRL: return a >> b[4:0];
            default: return DW'($signed(a) >>> b[4:0]);
        endcase
    endfunction

    always_comb begin
        alu_result = alu_ref(alu_a, alu_b, alu_op);
        alu_zero   = (alu_result == '0);
    end

    typedef struct {
        logic [DW-1:0]    res;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             sb[$];
    logic [TAG_W-1:0] model_tag;
    int               model_stall;
    int               model_pushed;
    int               checks;
    int               errors;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: settle inputs, model the handshakes seen before the edge, then check hold.
    task automatic tick();
        logic             do_push;
        logic             do_pop;
        logic             do_hold;
        logic [DW-1:0]    h_res;
        logic             h_zero;
        logic [TAG_W-1:0] h_tag;
        exp_t             e;
        #1;
        do_push = in_valid && in_ready;
        do_pop  = out_valid && out_ready;
        do_hold = out_valid && !out_ready;
        h_res   = out_result;
        h_zero  = out_zero;
        h_tag   = out_tag;
        if (in_valid && !in_ready) model_stall++;
        if (do_pop) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_result", 64'(out_result), 64'(e.res));
                check("out_zero",   64'(out_zero),   64'(e.zero));
                check("out_tag",    64'(out_tag),    64'(e.tag));
            end
        end
        if (do_push) begin
            e.res  = alu_ref(in_a, in_b, in_op);
            e.zero = (e.res == '0);
            e.tag  = model_tag;
            model_tag = model_tag + 1'b1;
            model_pushed++;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (do_hold) begin
            check("hold_result", 64'(out_result), 64'(h_res));
            check("hold_zero",   64'(out_zero),   64'(h_zero));
            check("hold_tag",    64'(out_tag),    64'(h_tag));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        sb.delete();
        model_tag    = '0;
        model_stall  = 0;
        model_pushed = 0;
    endtask

    task automatic set_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] op);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    task automatic set_rand_op();
        logic [DW-1:0] a;
        a = $urandom;
        set_op(a, ($urandom_range(0, 3) == 0) ? a : DW'($urandom), 3'($urandom_range(0, 7)));
    endtask

    initial begin
        logic [TAG_W-1:0] tags [5];
        int               max_cnt;
        checks    = 0;
        errors    = 0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        do_reset();

        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_in_ready",   64'(in_ready),   64'd1);
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_zero",   64'(out_zero),   64'd0);
        check("rst_out_tag",    64'(out_tag),    64'd0);
        check("rst_alu_op",     64'(alu_op),     64'd0);
        check("rst_alu_a",      64'(alu_a),      64'd0);
        check("rst_stat_issued", 64'(stat_issued), 64'd0);
        check("rst_stat_stall",  64'(stat_stall),  64'd0);

        // Single ADD: head visible after the push edge, result one edge later.
        out_ready = 1'b1;
        set_op(32'd5, 32'd7, ALU_ADD);
        tick();
        in_valid = 1'b0;
        check("lat_out_valid_early", 64'(out_valid),  64'd0);
        check("lat_fifo_count",      64'(fifo_count), 64'd1);
        check("lat_alu_a",           64'(alu_a),      64'd5);
        check("lat_alu_b",           64'(alu_b),      64'd7);
        tick();
        check("add_out_valid",  64'(out_valid),  64'd1);
        check("add_out_result", 64'(out_result), 64'd12);
        check("add_out_zero",   64'(out_zero),   64'd0);
        check("add_out_tag",    64'(out_tag),    64'd0);
        check("add_fifo_empty", 64'(fifo_count), 64'd0);

        set_op(32'd9, 32'd9, ALU_SUB);
        tick();
        in_valid = 1'b0;
        tick();
        check("sub_out_result", 64'(out_result), 64'd0);
        check("sub_out_zero",   64'(out_zero),   64'd1);

        set_op(32'h8000_0000, 32'd4, ALU_SRA);
        tick();
        in_valid = 1'b0;
        tick();
        check("sra_out_result", 64'(out_result), 64'hF800_0000);
        check("sra_out_tag",    64'(out_tag),    64'd2);
        tick();
        check("sra_drained", 64'(out_valid), 64'd0);

        // Backpressure: DEPTH+1 accepted, then producer stalls.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            set_rand_op();
            tick();
        end
        check("bp_in_ready",   64'(in_ready),   64'd0);
        check("bp_fifo_count", 64'(fifo_count), 64'd4);
        check("bp_out_valid",  64'(out_valid),  64'd1);
        for (int i = 0; i < 3; i++) begin
            set_rand_op();
            tick();
        end
        check("bp_fifo_hold", 64'(fifo_count), 64'd4);
        check("bp_model_stall", 64'(model_stall), 64'd3);
`ifdef ALU_ISSUE_STATS_EN
        check("bp_stat_stall", 64'(stat_stall), 64'(model_stall));
`endif
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            check("bp_drain_valid", 64'(out_valid), 64'd1);
            tags[i] = out_tag;
            tick();
        end
        check("bp_tag0", 64'(tags[0]), 64'd0);
        check("bp_tag1", 64'(tags[1]), 64'd1);
        check("bp_tag2", 64'(tags[2]), 64'd2);
        check("bp_tag3", 64'(tags[3]), 64'd3);
        check("bp_tag4", 64'(tags[4]), 64'd0);
        check("bp_empty_valid", 64'(out_valid), 64'd0);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);
`ifdef ALU_ISSUE_STATS_EN
        check("bp_stat_issued", 64'(stat_issued), 64'(model_pushed));
`else
        check("stat_issued_off", 64'(stat_issued), 64'd0);
        check("stat_stall_off",  64'(stat_stall),  64'd0);
`endif

        // Streaming at full rate keeps at most one entry queued.
        max_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            set_rand_op();
            tick();
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("stream_max_count", 64'(max_cnt <= 1), 64'd1);
        check("stream_drained",   64'(out_valid),   64'd0);

        // Reset with work in flight, then the next op restarts tags.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_rand_op();
            tick();
        end
        check("mid_fifo_count", 64'(fifo_count), 64'd3);
        check("mid_out_valid",  64'(out_valid),  64'd1);
        set_rand_op();
        out_ready = 1'b1;
        do_reset();
        check("mrst_fifo_count", 64'(fifo_count), 64'd0);
        check("mrst_out_valid",  64'(out_valid),  64'd0);
        check("mrst_in_ready",   64'(in_ready),   64'd1);
        check("mrst_alu_op",     64'(alu_op),     64'd0);
        set_op(32'd1, 32'd2, ALU_XOR);
        tick();
        in_valid = 1'b0;
        tick();
        check("mrst_out_valid2", 64'(out_valid), 64'd1);
        check("mrst_out_tag",    64'(out_tag),   64'd0);
        tick();

        // Random producer and consumer stalls against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) set_rand_op();
            else in_valid = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2*DEPTH + 4; i++) begin
            tick();
        end
        check("rand_sb_empty",  64'(sb.size()),  64'd0);
        check("rand_out_valid", 64'(out_valid),  64'd0);
        check("rand_fifo_zero", 64'(fifo_count), 64'd0);
`ifdef ALU_ISSUE_STATS_EN
        check("rand_stat_stall",  64'(stat_stall),  64'(model_stall));
        check("rand_stat_issued", 64'(stat_issued), 64'(model_pushed));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
